miim_ctrl: RTL and testbench
============================

# miim_ctrl

MDIO (IEEE 802.3 clause 22) management master that sequences read and write frames to the Ethernet PHY over MDC/MDIO. It sits between the register bus (settings/readback) and the PHY's management pins. It generates MDC from the system clock, serializes a single command per frame, and returns read data together with a no-PHY error flag. The tristate MDIO buffer is instantiated at the top level; this block drives only the output-enable and data lines.

## Interface
- CLK_DIV, 25: MDC half-period in clk cycles, legal range 1..255; 25 gives 2 MHz MDC from a 100 MHz clk.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_phyad  in  5  PHY address.
- cmd_regad  in  5  register address.
- cmd_wdata  in  16  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse at the end of every frame, read or write.
- rsp_rdata  out  16  read data; holds its value until the next read completes.
- rsp_err  out  1  qualified by rsp_valid; high when a read saw TA bit 2 = 1, i.e. no PHY responded.
- mdc_o  out  1  management clock.
- mdio_o  out  1  MDIO output data.
- mdio_oe  out  1  MDIO output enable.
- mdio_i  in  1  MDIO input; already synchronized at the top level.

## Operation
- States: IDLE, PRE (32 ones), ST (01), OP, PHYAD, REGAD, TA, DATA, DONE.
- OP encoding: read = 10, write = 01.
- Fields are shifted out MSB first.
- On acceptance, latch command fields into a 32-bit shift register.
- Write frame: TA is driven as 10; mdio_oe stays high through the last DATA bit.
- Read frame:
  - mdio_oe drops at the start of TA bit 1 and stays low through DATA.
  - TA bit 2 is sampled. If it is 1, rsp_err is set, but all 16 DATA bits are still clocked and sampled.
  - rsp_rdata updates only on a read's DONE, including an erroring read.
- DONE lasts 1 cycle: rsp_valid = 1, mdio_oe = 0, then the FSM returns to IDLE.
- cmd_valid while busy is ignored. There is no queue, and cmd_ready = 0 in every state except IDLE.
- Between frames: mdc_o = 0, mdio_oe = 0, mdio_o = 1.

## Timing
- Each bit lasts 2*CLK_DIV clk cycles, counted by a phase counter p = 0..2*CLK_DIV-1.
- mdc_o = 0 for p < CLK_DIV and 1 otherwise.
- mdio_o and mdio_oe change only at p = 0, i.e. MDC low, giving the PHY CLK_DIV cycles of setup.
- mdio_i is sampled at p = CLK_DIV (the MDC rising edge).
- Frame length is 64 bits with preamble.
- Handshake at cycle T:
  - bit 0 starts at T+1;
  - the last bit ends at T+128*CLK_DIV;
  - rsp_valid is high at T+128*CLK_DIV+1;
  - cmd_ready is high again at T+128*CLK_DIV+2.
- Reset values: cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mdc_o = 0, mdio_o = 1, mdio_oe = 0, state = IDLE.
- rst asserted mid-frame: outputs go to reset values immediately (asynchronously), the frame is aborted, and no rsp_valid is issued.

## Configuration
- MIIM_CTRL_PRE_SUPPRESS_EN defined:
  - the 32-bit preamble is sent only on the first frame after reset;
  - later frames begin at ST and are 32 bits long;
  - latency becomes 64*CLK_DIV+1 cycles from handshake to rsp_valid.
- Undefined: every frame carries the full preamble.
- Ports are identical in both builds.

## Structure
- miim_pkg holds:
  - OP_READ/OP_WRITE constants;
  - ST, TA_WRITE and PRE_LEN constants;
  - field widths (PHYAD_W = 5, REGAD_W = 5, DATA_W = 16);
  - the FSM state enum.
- Sub-module miim_clkgen: phase counter with a run enable; outputs mdc_o plus one-cycle strobes tick_fall (p = 0) and tick_rise (p = CLK_DIV).
- The FSM and shift register advance only on these strobes.

## Test plan
- CLK_DIV = 2, write phyad 5'h01, regad 5'h00, wdata 16'h1140:
  - a PHY monitor decodes ST = 01, OP = 01, TA = 10, data 16'h1140;
  - rsp_valid at T+257 with rsp_err = 0.
- Read phyad 5'h01, regad 5'h02; PHY model drives TA bit 2 = 0 and data 16'h0141 on MDC falling edges:
  - rsp_rdata = 16'h0141, rsp_err = 0;
  - mdio_oe is low from TA bit 1 through DATA.
- Read with no PHY (pull-up, mdio_i = 1) -> rsp_err = 1, rsp_rdata = 16'hFFFF.
- cmd_valid held high continuously over two frames -> exactly one acceptance per frame; cmd_ready = 0 throughout each frame.
- rst asserted at bit 40 of a read:
  - mdio_oe = 0 and mdc_o = 0 immediately, with no rsp_valid;
  - the next command runs a full frame, including the preamble in the PRE_SUPPRESS build.
- MIIM_CTRL_PRE_SUPPRESS_EN, CLK_DIV = 2, two reads back-to-back -> latencies of 257 and 129 cycles.

Source files
------------

// File: rtl/miim_pkg.sv
// MDIO clause-22 management master: shared constants, field widths,
// FSM state enum and per-field bit-count helpers.
package miim_pkg;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;
    localparam int PRE_LEN = 32;
    localparam int FRAME_W = 32;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_DONE
    } miim_state_e;

    // Index of the last bit of a field (bit count minus one).
    function automatic logic [4:0] field_last(input miim_state_e s);
        logic [4:0] n;
        case (s)
            S_PRE:            n = 5'(PRE_LEN - 1);
            S_ST, S_OP, S_TA: n = 5'd1;
            S_PHYAD:          n = 5'(PHYAD_W - 1);
            S_REGAD:          n = 5'(REGAD_W - 1);
            S_DATA:           n = 5'(DATA_W - 1);
            default:          n = 5'd0;
        endcase
        return n;
    endfunction

    function automatic miim_state_e next_state(input miim_state_e s);
        miim_state_e n;
        case (s)
            S_PRE:   n = S_ST;
            S_ST:    n = S_OP;
            S_OP:    n = S_PHYAD;
            S_PHYAD: n = S_REGAD;
            S_REGAD: n = S_TA;
            S_TA:    n = S_DATA;
            S_DATA:  n = S_DONE;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/miim_clkgen.sv
// MDC generator: phase counter p = 0..2*CLK_DIV-1 running while run_i.
// Ports: clk, rst (async high), run_i; mdc_o, tick_fall_o, tick_rise_o.
// The strobes are high in the cycle whose closing clk edge enters
// p = 0 (tick_fall_o) or p = CLK_DIV (tick_rise_o), so logic clocked
// on them changes exactly at the MDC edge.
module miim_clkgen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic mdc_o,
    output logic tick_fall_o,
    output logic tick_rise_o
);

    localparam logic [8:0] P_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] P_HALF = 9'(CLK_DIV);
    localparam logic [8:0] P_PRER = 9'(CLK_DIV - 1);

    logic [8:0] p_q;
    logic [8:0] p_d;
    logic       mdc_q;

    always_comb begin
        p_d = '0;
        if (run_i && (p_q != P_LAST)) begin
            p_d = p_q + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            mdc_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            mdc_q <= (p_d >= P_HALF);
        end
    end

    assign mdc_o       = mdc_q;
    assign tick_fall_o = run_i && (p_q == P_LAST);
    assign tick_rise_o = run_i && (p_q == P_PRER);

endmodule

// File: rtl/miim_ctrl.sv
// MDIO clause-22 master: one read/write frame per accepted command.
// Ports: cmd_* request (valid/ready), rsp_* result, mdc_o/mdio_o/
// mdio_oe/mdio_i PHY pins. Option MIIM_CTRL_PRE_SUPPRESS_EN sends the
// preamble only on the first frame after reset.
module miim_ctrl
    import miim_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [PHYAD_W-1:0] cmd_phyad,
    input  logic [REGAD_W-1:0] cmd_regad,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic               mdc_o,
    output logic               mdio_o,
    output logic               mdio_oe,
    input  logic               mdio_i
);

    miim_state_e        state_q;
    miim_state_e        nxt;
    logic [4:0]         cnt_q;
    logic [FRAME_W-1:0] sh_q;
    logic [DATA_W-1:0]  rx_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               wr_q;
    logic               err_q;
    logic               rsp_err_q;
    logic               rsp_valid_q;
    logic               mdio_o_q;
    logic               mdio_oe_q;
    logic               run;
    logic               tick_fall;
    logic               tick_rise;
    logic [FRAME_W-1:0] frame_w;
`ifdef MIIM_CTRL_PRE_SUPPRESS_EN
    logic               pre_done_q;
`endif

    // Read frames carry all-ones in TA/DATA; the pins are released then.
    assign frame_w = {
        ST,
        cmd_write ? OP_WRITE : OP_READ,
        cmd_phyad,
        cmd_regad,
        cmd_write ? TA_WRITE : 2'b11,
        cmd_write ? cmd_wdata : {DATA_W{1'b1}}
    };

    assign run = (state_q != S_IDLE) && (state_q != S_DONE);
    assign nxt = next_state(state_q);

    miim_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run),
        .mdc_o       (mdc_o),
        .tick_fall_o (tick_fall),
        .tick_rise_o (tick_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
`ifdef MIIM_CTRL_PRE_SUPPRESS_EN
            pre_done_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sh_q      <= frame_w;
                        wr_q      <= cmd_write;
                        err_q     <= 1'b0;
                        mdio_oe_q <= 1'b1;
`ifdef MIIM_CTRL_PRE_SUPPRESS_EN
                        pre_done_q <= 1'b1;
                        if (pre_done_q) begin
                            state_q  <= S_ST;
                            cnt_q    <= field_last(S_ST);
                            mdio_o_q <= frame_w[FRAME_W-1];
                        end else begin
                            state_q  <= S_PRE;
                            cnt_q    <= field_last(S_PRE);
                            mdio_o_q <= 1'b1;
                        end
`else
                        state_q  <= S_PRE;
                        cnt_q    <= field_last(S_PRE);
                        mdio_o_q <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    // Sample on the MDC rising edge.
                    if (tick_rise && !wr_q) begin
                        if (state_q == S_TA && cnt_q == '0) begin
                            err_q <= mdio_i;
                        end
                        if (state_q == S_DATA) begin
                            rx_q <= {rx_q[DATA_W-2:0], mdio_i};
                        end
                    end
                    // Drive on the MDC falling edge (bit boundary).
                    if (tick_fall) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 5'd1;
                            if (state_q != S_PRE) begin
                                sh_q     <= {sh_q[FRAME_W-2:0], 1'b0};
                                mdio_o_q <= sh_q[FRAME_W-2];
                            end
                        end else if (state_q == S_DATA) begin
                            state_q     <= S_DONE;
                            mdio_oe_q   <= 1'b0;
                            mdio_o_q    <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err_q;
                            if (!wr_q) begin
                                rdata_q <= rx_q;
                            end
                        end else begin
                            state_q <= nxt;
                            cnt_q   <= field_last(nxt);
                            // The ST bit is already at the top of sh_q.
                            if (state_q == S_PRE) begin
                                mdio_o_q <= sh_q[FRAME_W-1];
                            end else begin
                                sh_q     <= {sh_q[FRAME_W-2:0], 1'b0};
                                mdio_o_q <= sh_q[FRAME_W-2];
                            end
                            if (nxt == S_TA) begin
                                mdio_oe_q <= wr_q;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_miim_ctrl.sv
// Bench for miim_ctrl: table of commands against a PHY model/monitor,
// scoreboard of expected responses, plus reset and back-to-back cases.
module tb_miim_ctrl;

    localparam int D = 2;
`ifdef MIIM_CTRL_PRE_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phyad = '0;
    logic [4:0]  cmd_regad = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mdc_o;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    miim_ctrl #(
        .CLK_DIV (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_phyad (cmd_phyad),
        .cmd_regad (cmd_regad),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mdc_o     (mdc_o),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic        present;
        logic [15:0] pdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        w;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          pre;
    } exp_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_viol = 0;
    logic busy = 1'b0;

    int          hs_cyc[$];
    int          rsp_cyc[$];
    logic [16:0] rsp_dat[$];
    logic [39:0] frame_log[$];
    exp_t        exp_q[$];
    int hs_rd = 0;
    int rsp_rd = 0;
    int frm_rd = 0;

    logic        phy_present = 1'b0;
    logic [15:0] phy_data = '0;
    bit          pre_sent = 1'b0;
    logic [15:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake / response logger.
    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
        end else begin
            if (busy && cmd_ready) ready_viol++;
            if (rsp_valid) begin
                busy = 1'b0;
                rsp_cyc.push_back(cyc);
                rsp_dat.push_back({rsp_err, rsp_rdata});
            end
            if (cmd_valid && cmd_ready) begin
                hs_cyc.push_back(cyc);
                busy = 1'b1;
            end
        end
    end

    // PHY-side monitor: decodes frames on MDC rising edges.
    logic        hunt = 1'b1;
    int          pos = 0;
    int          pre_cnt = 0;
    logic [31:0] fr = '0;
    logic [1:0]  mop = '0;
    logic        bad = 1'b0;
    logic        mb;

    always @(posedge mdc_o or posedge rst) begin
        if (rst) begin
            hunt = 1'b1;
            pos = 0;
            pre_cnt = 0;
            bad = 1'b0;
            mop = '0;
        end else if (hunt) begin
            if (mdio_oe && mdio_o) begin
                pre_cnt++;
            end else if (mdio_oe) begin
                hunt = 1'b0;
                pos = 1;
                fr = '0;
                bad = 1'b0;
            end
        end else begin
            mb = mdio_oe ? mdio_o : mdio_i;
            fr = {fr[30:0], mb};
            pos++;
            if (pos == 4) mop = fr[1:0];
            if (pos >= 5) begin
                if (mop == 2'b10 && pos >= 15 && mdio_oe) bad = 1'b1;
                if (mop != 2'b10 && !mdio_oe) bad = 1'b1;
            end
            if (pos == 32) begin
                frame_log.push_back({bad, 7'(pre_cnt), fr});
                hunt = 1'b1;
                pre_cnt = 0;
            end
        end
    end

    // PHY responder: drives TA bit 2 and read data on MDC falling edges.
    always @(negedge mdc_o or posedge rst) begin
        if (rst) begin
            mdio_i = 1'b1;
        end else if (!hunt && mop == 2'b10 && phy_present &&
                     pos >= 15 && pos <= 31) begin
            mdio_i = (pos == 15) ? 1'b0 : phy_data[31-pos];
        end else begin
            mdio_i = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic w, input logic [4:0] pa,
                                    input logic [4:0] ra,
                                    input logic [15:0] wd,
                                    input logic [15:0] rd,
                                    input logic er);
        exp_t e;
        e.w = w;
        e.pa = pa;
        e.ra = ra;
        e.wd = wd;
        e.rdata = rd;
        e.err = er;
        e.lat = (SUPP && pre_sent) ? 64 * D + 1 : 128 * D + 1;
        e.pre = (SUPP && pre_sent) ? 0 : 32;
        return e;
    endfunction

    task automatic issue(input logic w, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd);
        int n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            cmd_valid = 1'b1;
            cmd_write = w;
            cmd_phyad = pa;
            cmd_regad = ra;
            cmd_wdata = wd;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic collect();
        exp_t        e;
        int          n = 0;
        logic [39:0] f;
        logic [16:0] r;
        e = exp_q.pop_front();
        while (rsp_cyc.size() <= rsp_rd && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (rsp_cyc.size() <= rsp_rd) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        r = rsp_dat[rsp_rd];
        chk("latency", 32'(rsp_cyc[rsp_rd] - hs_cyc[hs_rd]), 32'(e.lat));
        chk("rsp_err", 32'(r[16]), 32'(e.err));
        chk("rsp_rdata", 32'(r[15:0]), 32'(e.rdata));
        rsp_rd++;
        hs_rd++;
        if (frame_log.size() <= frm_rd) begin
            chk("frame_missing", 32'd0, 32'd1);
            return;
        end
        f = frame_log[frm_rd];
        frm_rd++;
        chk("frame_hdr", 32'(f[31:18]),
            32'({2'b01, (e.w ? 2'b01 : 2'b10), e.pa, e.ra}));
        if (e.w) chk("frame_ta_data", 32'(f[17:0]), 32'({2'b10, e.wd}));
        chk("mdio_oe_window", 32'(f[39]), 32'd0);
        chk("preamble_len", 32'(f[38:32]), 32'(e.pre));
        if (!e.w) last_rd = e.rdata;
    endtask

    task automatic send(input vec_t v);
        phy_present = v.present;
        phy_data = v.pdata;
        exp_q.push_back(mk_exp(v.w, v.pa, v.ra, v.wd, v.exp_rdata,
                               v.exp_err));
        pre_sent = 1'b1;
        issue(v.w, v.pa, v.ra, v.wd);
        collect();
    endtask

    vec_t tbl[7];

    initial begin
        int t0;
        int n;
        int r0;
        int a0;
        int rv0;
        tbl[0] = '{1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000,
                   16'h0000, 1'b0};
        tbl[1] = '{1'b0, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0141,
                   16'h0141, 1'b0};
        tbl[2] = '{1'b0, 5'h03, 5'h01, 16'h0000, 1'b0, 16'h0000,
                   16'hFFFF, 1'b1};
        tbl[3] = '{1'b1, 5'h1f, 5'h1f, 16'hFFFF, 1'b0, 16'h0000,
                   16'hFFFF, 1'b0};
        tbl[4] = '{1'b0, 5'h1f, 5'h1f, 16'h0000, 1'b1, 16'h0000,
                   16'h0000, 1'b0};
        tbl[5] = '{1'b0, 5'h10, 5'h0a, 16'h0000, 1'b1, 16'hA5A5,
                   16'hA5A5, 1'b0};
        tbl[6] = '{1'b1, 5'h00, 5'h15, 16'h0000, 1'b0, 16'h0000,
                   16'hA5A5, 1'b0};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mdc", 32'(mdc_o), 32'd0);
        chk("rst_mdio_o", 32'(mdio_o), 32'd1);
        chk("rst_mdio_oe", 32'(mdio_oe), 32'd0);

        // Abort a read during bit 40 while MDC is high.
        phy_present = 1'b1;
        phy_data = 16'h1234;
        pre_sent = 1'b1;
        issue(1'b0, 5'h01, 5'h02, 16'h0000);
        t0 = (hs_cyc.size() > hs_rd) ? hs_cyc[hs_rd] : cyc;
        n = 0;
        while (cyc != t0 + 1 + 40 * 2 * D + D && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_rst_mdc", 32'(mdc_o), 32'd1);
        chk("pre_rst_oe", 32'(mdio_oe), 32'd1);
        r0 = rsp_cyc.size();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_oe", 32'(mdio_oe), 32'd0);
        chk("async_rst_mdc", 32'(mdc_o), 32'd0);
        chk("async_rst_mdio_o", 32'(mdio_o), 32'd1);
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hs_rd = hs_cyc.size();
        frm_rd = frame_log.size();
        pre_sent = 1'b0;
        last_rd = '0;
        repeat (300) @(posedge clk);
        chk("no_rsp_after_rst", 32'(rsp_cyc.size() - r0), 32'd0);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i]);
        end

        // cmd_valid held across two frames: one acceptance per frame.
        phy_present = 1'b0;
        exp_q.push_back(mk_exp(1'b1, 5'h0a, 5'h0b, 16'hBEEF, last_rd,
                               1'b0));
        exp_q.push_back(mk_exp(1'b1, 5'h0a, 5'h0b, 16'hBEEF, last_rd,
                               1'b0));
        a0 = hs_cyc.size();
        rv0 = ready_viol;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_phyad = 5'h0a;
        cmd_regad = 5'h0b;
        cmd_wdata = 16'hBEEF;
        n = 0;
        while (hs_cyc.size() < a0 + 2 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        collect();
        collect();
        repeat (10) @(posedge clk);
        chk("hold_accepts", 32'(hs_cyc.size() - a0), 32'd2);
        chk("hold_ready_low", 32'(ready_viol - rv0), 32'd0);
        chk("ready_low_total", 32'(ready_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
